// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one registered add/subtract datapath among NREQ requesters.
// Optional carry/borrow output is enabled by defining ADDSUB_ARB_CARRY_EN.
module addsub_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ-1:0]       req_sign,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_z
`ifdef ADDSUB_ARB_CARRY_EN
  ,
  output logic                  rsp_carry
`endif
);

  typedef enum logic {EMPTY, FULL} state_e;

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_z_q;

  logic             found;
  logic [IDW-1:0]   winner;
  logic             can_accept;
  logic             grant;
  logic [WIDTH-1:0] x_sel, y_sel, z_calc;
  logic             sign_sel;

  // Rotating priority search: first valid requester at or after the pointer wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    logic [IDW:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IDW-1:0];
      end
    end
  end

  assign rsp_valid  = (state_q == FULL);
  // Gated by rst_n so no request is acknowledged while the block is held in reset.
  assign can_accept = rst_n & ((state_q == EMPTY) | (rsp_valid & rsp_ready));
  assign grant      = found & can_accept;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign x_sel    = req_x[winner*WIDTH +: WIDTH];
  assign y_sel    = req_y[winner*WIDTH +: WIDTH];
  assign sign_sel = req_sign[winner];

`ifdef ADDSUB_ARB_CARRY_EN
  logic [WIDTH:0] ext_calc;
  logic           carry_q;

  // The extra top bit is the add carry-out, or the borrow when x < y on subtract.
  assign ext_calc = sign_sel ? ({1'b0, x_sel} - {1'b0, y_sel})
                             : ({1'b0, x_sel} + {1'b0, y_sel});
  assign z_calc   = ext_calc[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     carry_q <= 1'b0;
    else if (grant) carry_q <= ext_calc[WIDTH];
  end

  assign rsp_carry = carry_q;
`else
  assign z_calc = sign_sel ? (x_sel - y_sel) : (x_sel + y_sel);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (grant) ptr_d = (winner == LAST) ? '0 : winner + 1'b1;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (grant) state_d = FULL;
               else if (rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so all registers sample together.
      state_q  <= EMPTY;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      rsp_z_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        rsp_id_q <= winner;
        rsp_z_q  <= z_calc;
      end
    end
  end

  assign rsp_id = rsp_id_q;
  assign rsp_z  = rsp_z_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_addsub_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       req_sign;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_z;
`ifdef ADDSUB_ARB_CARRY_EN
  logic                  rsp_carry;
`endif

  addsub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_sign  (req_sign),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z)
`ifdef ADDSUB_ARB_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a one-entry result buffer plus the round-robin start index.
  int              m_ptr   = 0;
  bit              m_full  = 0;
  int              m_id    = 0;
  logic [WIDTH-1:0] m_z    = '0;
  logic            m_carry = 1'b0;
  logic [NREQ-1:0] last_ready = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s);
    req_x[i*WIDTH +: WIDTH] = x;
    req_y[i*WIDTH +: WIDTH] = y;
    req_sign[i]             = s;
  endtask

  // Checks the combinational grant for the current inputs, advances the model,
  // then checks the registered response just after the clock edge.
  task automatic step(input string tag);
    int               w;
    logic [NREQ-1:0]  exp_ready;
    logic [WIDTH-1:0] x, y;
    logic [WIDTH:0]   wide;
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (w < 0 && req_valid[c]) w = c;
    end
    exp_ready = '0;
    if (w >= 0 && (!m_full || rsp_ready)) exp_ready[w] = 1'b1;
    check({tag, "/ready"}, 64'(req_ready), 64'(exp_ready));
    last_ready = exp_ready;
    if (exp_ready != '0) begin
      x = req_x[w*WIDTH +: WIDTH];
      y = req_y[w*WIDTH +: WIDTH];
      if (req_sign[w]) begin
        m_z     = x - y;
        m_carry = (x < y);
      end else begin
        wide    = {1'b0, x} + {1'b0, y};
        m_z     = wide[WIDTH-1:0];
        m_carry = wide[WIDTH];
      end
      m_full = 1;
      m_id   = w;
      m_ptr  = (w + 1) % NREQ;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    check({tag, "/rsp_valid"}, 64'(rsp_valid), 64'(m_full));
    if (m_full) begin
      check({tag, "/rsp_id"}, 64'(rsp_id), 64'(m_id));
      check({tag, "/rsp_z"},  64'(rsp_z),  64'(m_z));
`ifdef ADDSUB_ARB_CARRY_EN
      check({tag, "/rsp_carry"}, 64'(rsp_carry), 64'(m_carry));
`endif
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return WIDTH'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    req_sign  = '0;
    rsp_ready = 1'b1;
    #1;
    check("reset/rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset/rsp_id",    64'(rsp_id),    64'd0);
    check("reset/rsp_z",     64'(rsp_z),     64'd0);
    check("reset/req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single add from requester 0.
    req_valid = 4'b0001;
    set_op(0, 32'd5, 32'd7, 1'b0);
    step("single");
    check("single/z_const",  64'(rsp_z),  64'd12);
    check("single/id_const", 64'(rsp_id), 64'd0);

    // Pointer at 1: requester 3 wins ahead of 0, then wrap back to 0.
    req_valid = 4'b1001;
    set_op(3, 32'd100, 32'd1, 1'b1);
    step("skip1");
    check("skip1/id_const", 64'(rsp_id), 64'd3);
    check("skip1/z_const",  64'(rsp_z),  64'd99);
    step("skip2");
    check("skip2/id_const", 64'(rsp_id), 64'd0);

    // Subtract underflow wraps.
    req_valid = 4'b0100;
    set_op(2, 32'd0, 32'd1, 1'b1);
    step("subwrap");
    check("subwrap/z_const",  64'(rsp_z),  64'hFFFF_FFFF);
    check("subwrap/id_const", 64'(rsp_id), 64'd2);
`ifdef ADDSUB_ARB_CARRY_EN
    check("subwrap/borrow_const", 64'(rsp_carry), 64'd1);
`endif

    // Move pointer back to 0, then drain.
    req_valid = 4'b1000;
    step("realign");
    req_valid = 4'b0000;
    step("drain");
    check("drain/valid_const", 64'(rsp_valid), 64'd0);

    // All requesters valid: strict rotation, one result per cycle.
    for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(10 * i), WIDTH'(i), 1'b0);
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      step("rr");
      check("rr/id_const", 64'(rsp_id), 64'(n % NREQ));
      check("rr/z_const",  64'(rsp_z),  64'(11 * (n % NREQ)));
    end

    // Backpressure: result held, no grants, then a grant in the release cycle.
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step("bp");
      check("bp/id_const", 64'(rsp_id), 64'd1);
      check("bp/z_const",  64'(rsp_z),  64'd11);
    end
    rsp_ready = 1'b1;
    step("bp_release");
    check("bp_release/id_const", 64'(rsp_id), 64'd2);

    // Asynchronous reset while holding a result.
    rsp_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("areset/rsp_valid", 64'(rsp_valid), 64'd0);
    check("areset/req_ready", 64'(req_ready), 64'd0);
    check("areset/rsp_z",     64'(rsp_z),     64'd0);
    m_full = 0;
    m_ptr  = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    step("post_reset");
    check("post_reset/id_const", 64'(rsp_id), 64'd0);

    // Randomized traffic honouring the hold-while-waiting rule.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !last_ready[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_op(i, rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
